// File: rtl/xg_seq_pkg.sv
// Shared types and constants for the XAUI loopback test sequencer.
// Imported by xg_sat_counter and xg_test_sequencer.
package xg_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LINK_RST = 3'd1,
      ST_ALIGN    = 3'd2,
      ST_SEND     = 3'd3,
      ST_DRAIN    = 3'd4,
      ST_DONE     = 3'd5,
      ST_FAIL     = 3'd6
   } seq_state_t;

   localparam logic [1:0] FAIL_NONE  = 2'd0;
   localparam logic [1:0] FAIL_ALIGN = 2'd1;
   localparam logic [1:0] FAIL_DRAIN = 2'd2;
   localparam logic [1:0] FAIL_ABORT = 2'd3;

   localparam int ALIGN_STABLE     = 16;
   localparam int LINK_LOSS_CYCLES = 4;

endpackage

// File: rtl/xg_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module xg_sat_counter
   import xg_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/xg_test_sequencer.sv
// Run controller for the XAUI loopback tester: link bring-up, frame requests, result drain.
// Define XGSEQ_LINK_MON_EN to fail a run on sustained link loss during SEND and DRAIN.
module xg_test_sequencer
   import xg_seq_pkg::*;
#(
   parameter int CNT_W         = 32,
   parameter int LEN_W         = 14,
   parameter int RST_CYCLES    = 64,
   parameter int ALIGN_TIMEOUT = 156250,
   parameter int DRAIN_TIMEOUT = 4096
) (
   input  logic             clk156,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] cfg_count,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [3:0]       sync_status,
   input  logic             align_status,
   output logic             xaui_reset,
   output logic             gen_valid,
   input  logic             gen_ready,
   output logic [LEN_W-1:0] gen_len,
   input  logic             rx_ok,
   input  logic             rx_err,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [1:0]       fail_code,
   output logic [CNT_W-1:0] tx_cnt,
   output logic [CNT_W-1:0] rx_ok_cnt,
   output logic [CNT_W-1:0] rx_err_cnt
);

   localparam logic [31:0] RST_LAST    = 32'(RST_CYCLES - 1);
   localparam logic [31:0] ALIGN_LAST  = 32'(ALIGN_TIMEOUT - 1);
   localparam logic [31:0] DRAIN_LAST  = 32'(DRAIN_TIMEOUT - 1);
   localparam logic [4:0]  STABLE_LAST = 5'(ALIGN_STABLE - 1);

   seq_state_t       state, next_state;
   logic [31:0]      timer;
   logic [4:0]       stable_cnt;
   logic [CNT_W-1:0] cfg_count_q;
   logic [LEN_W-1:0] cfg_len_q;
   logic             pass_q;
   logic [1:0]       fail_code_q;
   logic             fail_set;
   logic [1:0]       fail_val;
   logic             link_ok;
   logic             link_lost;
   logic             start_accept;
   logic             drain_complete;

   assign link_ok        = (sync_status == 4'hF) && align_status;
   assign start_accept   = start && !abort &&
                           ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAIL));
   assign drain_complete = ({1'b0, rx_ok_cnt} + {1'b0, rx_err_cnt}) >= {1'b0, cfg_count_q};

`ifdef XGSEQ_LINK_MON_EN
   logic [1:0] loss_cnt;

   // Counts consecutive bad-link cycles; any good cycle or state change restarts it.
   always_ff @(posedge clk156) begin
      if (reset) begin
         loss_cnt <= '0;
      end else if (((state == ST_SEND) || (state == ST_DRAIN)) &&
                   (next_state == state) && !link_ok) begin
         loss_cnt <= loss_cnt + 1'b1;
      end else begin
         loss_cnt <= '0;
      end
   end

   assign link_lost = ((state == ST_SEND) || (state == ST_DRAIN)) && !link_ok &&
                      (loss_cnt == 2'(LINK_LOSS_CYCLES - 1));
`else
   assign link_lost = 1'b0;
`endif

   always_comb begin
      next_state = state;
      fail_set   = 1'b0;
      fail_val   = FAIL_NONE;
      if (abort && (state != ST_IDLE)) begin
         next_state = ST_FAIL;
         if (state != ST_FAIL) begin
            fail_set = 1'b1;
            fail_val = FAIL_ABORT;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_accept) next_state = ST_LINK_RST;
            end
            ST_LINK_RST: begin
               if (timer == RST_LAST) next_state = ST_ALIGN;
            end
            ST_ALIGN: begin
               if (link_ok && (stable_cnt == STABLE_LAST)) begin
                  next_state = (cfg_count_q == '0) ? ST_DONE : ST_SEND;
               end else if (timer == ALIGN_LAST) begin
                  next_state = ST_FAIL;
                  fail_set   = 1'b1;
                  fail_val   = FAIL_ALIGN;
               end
            end
            ST_SEND: begin
               if (link_lost) begin
                  next_state = ST_FAIL;
                  fail_set   = 1'b1;
                  fail_val   = FAIL_ABORT;
               end else if (gen_ready && (tx_cnt == (cfg_count_q - 1'b1))) begin
                  next_state = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (link_lost) begin
                  next_state = ST_FAIL;
                  fail_set   = 1'b1;
                  fail_val   = FAIL_ABORT;
               end else if (drain_complete) begin
                  next_state = ST_DONE;
               end else if (timer == DRAIN_LAST) begin
                  next_state = ST_FAIL;
                  fail_set   = 1'b1;
                  fail_val   = FAIL_DRAIN;
               end
            end
            ST_DONE, ST_FAIL: begin
               if (start_accept) next_state = ST_LINK_RST;
            end
            default: next_state = ST_IDLE;
         endcase
      end
   end

   // State register; the shared timer and stable counter restart on every state change.
   always_ff @(posedge clk156) begin
      if (reset) begin
         state      <= ST_IDLE;
         timer      <= '0;
         stable_cnt <= '0;
      end else begin
         state      <= next_state;
         timer      <= (next_state != state) ? '0 : timer + 1'b1;
         stable_cnt <= ((state == ST_ALIGN) && (next_state == state) && link_ok) ?
                       stable_cnt + 1'b1 : '0;
      end
   end

   // Per-run configuration and verdict; pass is captured once, on the way into DONE.
   always_ff @(posedge clk156) begin
      if (reset) begin
         cfg_count_q <= '0;
         cfg_len_q   <= '0;
         pass_q      <= 1'b0;
         fail_code_q <= FAIL_NONE;
      end else begin
         if (start_accept) begin
            cfg_count_q <= cfg_count;
            cfg_len_q   <= cfg_len;
            pass_q      <= 1'b0;
            fail_code_q <= FAIL_NONE;
         end
         if (fail_set) fail_code_q <= fail_val;
         if ((next_state == ST_DONE) && (state != ST_DONE)) begin
            pass_q <= (rx_ok_cnt == cfg_count_q) && (rx_err_cnt == '0);
         end
      end
   end

   xg_sat_counter #(.WIDTH(CNT_W)) u_tx_cnt (
      .clk(clk156), .reset(reset), .clear(start_accept),
      .inc(gen_valid && gen_ready), .count(tx_cnt)
   );

   xg_sat_counter #(.WIDTH(CNT_W)) u_rx_ok_cnt (
      .clk(clk156), .reset(reset), .clear(start_accept),
      .inc(rx_ok), .count(rx_ok_cnt)
   );

   xg_sat_counter #(.WIDTH(CNT_W)) u_rx_err_cnt (
      .clk(clk156), .reset(reset), .clear(start_accept),
      .inc(rx_err), .count(rx_err_cnt)
   );

   assign xaui_reset = (state == ST_IDLE) || (state == ST_LINK_RST);
   assign gen_valid  = (state == ST_SEND);
   assign gen_len    = cfg_len_q;
   assign busy       = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_FAIL);
   assign done       = (state == ST_DONE);
   assign pass       = pass_q;
   assign fail_code  = fail_code_q;

endmodule

// File: tb/tb_xg_test_sequencer.sv
// Directed self-checking bench for xg_test_sequencer with shortened timeouts and 8-bit counters.
// Link-loss expectations follow XGSEQ_LINK_MON_EN.
module tb_xg_test_sequencer;

   localparam int CNT_W         = 8;
   localparam int LEN_W         = 14;
   localparam int RST_CYCLES    = 16;
   localparam int ALIGN_TIMEOUT = 1000;
   localparam int DRAIN_TIMEOUT = 200;

   logic             clk156 = 1'b0;
   logic             reset, start, abort;
   logic [CNT_W-1:0] cfg_count;
   logic [LEN_W-1:0] cfg_len;
   logic [3:0]       sync_status;
   logic             align_status;
   logic             xaui_reset, gen_valid, gen_ready;
   logic [LEN_W-1:0] gen_len;
   logic             rx_ok, rx_err, busy, done, pass;
   logic [1:0]       fail_code;
   logic [CNT_W-1:0] tx_cnt, rx_ok_cnt, rx_err_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   always #3 clk156 = ~clk156;

   xg_test_sequencer #(
      .CNT_W(CNT_W), .LEN_W(LEN_W), .RST_CYCLES(RST_CYCLES),
      .ALIGN_TIMEOUT(ALIGN_TIMEOUT), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
   ) dut (
      .clk156(clk156), .reset(reset), .start(start), .abort(abort),
      .cfg_count(cfg_count), .cfg_len(cfg_len), .sync_status(sync_status),
      .align_status(align_status), .xaui_reset(xaui_reset), .gen_valid(gen_valid),
      .gen_ready(gen_ready), .gen_len(gen_len), .rx_ok(rx_ok), .rx_err(rx_err),
      .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
      .tx_cnt(tx_cnt), .rx_ok_cnt(rx_ok_cnt), .rx_err_cnt(rx_err_cnt)
   );

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk156);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0; rx_ok = 1'b0; rx_err = 1'b0;
      tick(1);
      reset = 1'b0;
   endtask

   task automatic start_run(input logic [CNT_W-1:0] count, input logic [LEN_W-1:0] len);
      cfg_count = count; cfg_len = len; start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic reach_send(input logic [CNT_W-1:0] count, input logic [LEN_W-1:0] len);
      sync_status = 4'hF; align_status = 1'b1;
      start_run(count, len);
      tick(RST_CYCLES + 16);
   endtask

   task automatic test_reset();
      tests_run++;
      if (xaui_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_xaui_reset: got %0b expected 1", xaui_reset); end
      tests_run++;
      if ({gen_valid, busy, done, pass} !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_flags: got %4b expected 0000", {gen_valid, busy, done, pass}); end
      tests_run++;
      if (fail_code !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_fail_code: got %0d expected 0", fail_code); end
      tests_run++;
      if ({tx_cnt, rx_ok_cnt, rx_err_cnt} !== 24'd0) begin tests_failed++; $display("[TB] FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", tx_cnt, rx_ok_cnt, rx_err_cnt); end
   endtask

   task automatic test_link_rst_window();
      apply_reset();
      sync_status = 4'hF; align_status = 1'b1;
      start_run(8'd3, 14'd64);
      tick(RST_CYCLES - 1);
      tests_run++;
      if ({xaui_reset, busy} !== 2'b11) begin tests_failed++; $display("[TB] FAIL link_rst_last_cycle: got xaui_reset/busy %2b expected 11", {xaui_reset, busy}); end
      tick(1);
      tests_run++;
      if (xaui_reset !== 1'b0) begin tests_failed++; $display("[TB] FAIL align_entry_xaui_reset: got %0b expected 0", xaui_reset); end
      tick(15);
      tests_run++;
      if (gen_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL align_15_stable: got gen_valid %0b expected 0", gen_valid); end
      tick(1);
      tests_run++;
      if (gen_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL align_16_stable: got gen_valid %0b expected 1", gen_valid); end
   endtask

   task automatic test_full_run();
      apply_reset();
      sync_status = 4'hF; align_status = 1'b0; gen_ready = 1'b1;
      start_run(8'd10, 14'd1500);
      tick(RST_CYCLES + 200);
      tests_run++;
      if ({gen_valid, busy} !== 2'b01) begin tests_failed++; $display("[TB] FAIL full_pre_align: got gen_valid/busy %2b expected 01", {gen_valid, busy}); end
      align_status = 1'b1;
      tick(16);
      tests_run++;
      if (gen_len !== 14'd1500) begin tests_failed++; $display("[TB] FAIL full_gen_len: got %0d expected 1500", gen_len); end
      tick(9);
      tests_run++;
      if ({gen_valid, tx_cnt} !== {1'b1, 8'd9}) begin tests_failed++; $display("[TB] FAIL full_send_9: got valid %0b tx %0d expected 1 9", gen_valid, tx_cnt); end
      tick(1);
      tests_run++;
      if ({gen_valid, tx_cnt} !== {1'b0, 8'd10}) begin tests_failed++; $display("[TB] FAIL full_send_10: got valid %0b tx %0d expected 0 10", gen_valid, tx_cnt); end
      rx_ok = 1'b1;
      tick(10);
      rx_ok = 1'b0;
      tests_run++;
      if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_drain_latency: got done %0b expected 0", done); end
      tick(1);
      tests_run++;
      if ({done, pass, busy, fail_code, rx_ok_cnt} !== {3'b110, 2'd0, 8'd10}) begin
         tests_failed++;
         $display("[TB] FAIL full_done: got done %0b pass %0b busy %0b code %0d ok %0d expected 1 1 0 0 10", done, pass, busy, fail_code, rx_ok_cnt);
      end
      rx_err = 1'b1;
      tick(1);
      rx_err = 1'b0;
      tests_run++;
      if ({rx_err_cnt, pass, done} !== {8'd1, 2'b11}) begin tests_failed++; $display("[TB] FAIL full_late_result: got err %0d pass %0b done %0b expected 1 1 1", rx_err_cnt, pass, done); end
   endtask

   task automatic test_align_timeout();
      logic seen_valid;
      apply_reset();
      sync_status = 4'hF; align_status = 1'b0; gen_ready = 1'b1;
      start_run(8'd4, 14'd100);
      tick(RST_CYCLES);
      seen_valid = 1'b0;
      for (int i = 0; i < ALIGN_TIMEOUT - 1; i++) begin
         tick(1);
         if (gen_valid !== 1'b0) seen_valid = 1'b1;
      end
      tests_run++;
      if ({busy, fail_code} !== {1'b1, 2'd0}) begin tests_failed++; $display("[TB] FAIL align_before_timeout: got busy %0b code %0d expected 1 0", busy, fail_code); end
      tick(1);
      tests_run++;
      if ({busy, done, fail_code} !== {2'b00, 2'd1}) begin tests_failed++; $display("[TB] FAIL align_timeout: got busy %0b done %0b code %0d expected 0 0 1", busy, done, fail_code); end
      tests_run++;
      if ((seen_valid | gen_valid) !== 1'b0) begin tests_failed++; $display("[TB] FAIL align_no_valid: got gen_valid seen 1 expected 0"); end
   endtask

   task automatic test_ready_throttle();
      int   xfers;
      logic hold_bad, prev_stall;
      apply_reset();
      gen_ready = 1'b0;
      reach_send(8'd5, 14'd777);
      tests_run++;
      if ({gen_valid, gen_len} !== {1'b1, 14'd777}) begin tests_failed++; $display("[TB] FAIL throttle_entry: got valid %0b len %0d expected 1 777", gen_valid, gen_len); end
      xfers = 0; hold_bad = 1'b0; prev_stall = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (prev_stall && ((gen_valid !== 1'b1) || (gen_len !== 14'd777))) hold_bad = 1'b1;
         gen_ready = ((i % 3) == 2);
         if ((gen_valid === 1'b1) && gen_ready) xfers++;
         prev_stall = (gen_valid === 1'b1) && !gen_ready;
         tick(1);
      end
      gen_ready = 1'b0;
      tests_run++;
      if (xfers != 5) begin tests_failed++; $display("[TB] FAIL throttle_transfers: got %0d expected 5", xfers); end
      tests_run++;
      if ({tx_cnt, gen_valid} !== {8'd5, 1'b0}) begin tests_failed++; $display("[TB] FAIL throttle_tx_cnt: got tx %0d valid %0b expected 5 0", tx_cnt, gen_valid); end
      tests_run++;
      if (hold_bad !== 1'b0) begin tests_failed++; $display("[TB] FAIL throttle_hold: got unstable request expected held"); end
   endtask

   task automatic test_mixed_results();
      apply_reset();
      gen_ready = 1'b1;
      reach_send(8'd5, 14'd64);
      tick(5);
      rx_ok = 1'b1;
      tick(4);
      rx_err = 1'b1;
      tick(1);
      rx_ok = 1'b0; rx_err = 1'b0;
      tick(1);
      tests_run++;
      if ({rx_ok_cnt, rx_err_cnt} !== {8'd5, 8'd1}) begin tests_failed++; $display("[TB] FAIL mixed_counts: got ok %0d err %0d expected 5 1", rx_ok_cnt, rx_err_cnt); end
      tests_run++;
      if ({done, pass} !== 2'b10) begin tests_failed++; $display("[TB] FAIL mixed_verdict: got done %0b pass %0b expected 1 0", done, pass); end
   endtask

   task automatic test_abort();
      apply_reset();
      gen_ready = 1'b1;
      reach_send(8'd10, 14'd200);
      tick(3);
      gen_ready = 1'b0; abort = 1'b1;
      tick(1);
      tests_run++;
      if ({gen_valid, busy, fail_code, tx_cnt} !== {2'b00, 2'd3, 8'd3}) begin
         tests_failed++;
         $display("[TB] FAIL abort_send: got valid %0b busy %0b code %0d tx %0d expected 0 0 3 3", gen_valid, busy, fail_code, tx_cnt);
      end
      cfg_count = 8'd2; start = 1'b1;
      tick(1);
      start = 1'b0; abort = 1'b0;
      tests_run++;
      if ({busy, fail_code, tx_cnt} !== {1'b0, 2'd3, 8'd3}) begin tests_failed++; $display("[TB] FAIL abort_beats_start: got busy %0b code %0d tx %0d expected 0 3 3", busy, fail_code, tx_cnt); end
      start_run(8'd2, 14'd200);
      tests_run++;
      if ({busy, xaui_reset, fail_code, tx_cnt} !== {2'b11, 2'd0, 8'd0}) begin
         tests_failed++;
         $display("[TB] FAIL abort_restart: got busy %0b xrst %0b code %0d tx %0d expected 1 1 0 0", busy, xaui_reset, fail_code, tx_cnt);
      end
      gen_ready = 1'b1;
      tick(RST_CYCLES + 16 + 2);
      rx_ok = 1'b1;
      tick(2);
      rx_ok = 1'b0;
      tick(1);
      tests_run++;
      if ({done, pass, tx_cnt} !== {2'b11, 8'd2}) begin tests_failed++; $display("[TB] FAIL abort_rerun_done: got done %0b pass %0b tx %0d expected 1 1 2", done, pass, tx_cnt); end
   endtask

   task automatic test_drain_timeout();
      apply_reset();
      gen_ready = 1'b1;
      reach_send(8'd2, 14'd64);
      tick(2);
      tick(DRAIN_TIMEOUT - 1);
      tests_run++;
      if ({busy, fail_code} !== {1'b1, 2'd0}) begin tests_failed++; $display("[TB] FAIL drain_before_timeout: got busy %0b code %0d expected 1 0", busy, fail_code); end
      tick(1);
      tests_run++;
      if ({busy, fail_code} !== {1'b0, 2'd2}) begin tests_failed++; $display("[TB] FAIL drain_timeout: got busy %0b code %0d expected 0 2", busy, fail_code); end
   endtask

   task automatic test_link_loss();
      apply_reset();
      gen_ready = 1'b1;
      reach_send(8'd2, 14'd64);
      tick(2);
      align_status = 1'b0;
      tick(3);
      align_status = 1'b1;
      tick(1);
      tests_run++;
      if ({busy, fail_code} !== {1'b1, 2'd0}) begin tests_failed++; $display("[TB] FAIL link_loss_3: got busy %0b code %0d expected 1 0", busy, fail_code); end
      align_status = 1'b0;
      tick(4);
      align_status = 1'b1;
`ifdef XGSEQ_LINK_MON_EN
      tests_run++;
      if ({busy, fail_code} !== {1'b0, 2'd3}) begin tests_failed++; $display("[TB] FAIL link_loss_4: got busy %0b code %0d expected 0 3", busy, fail_code); end
`else
      tests_run++;
      if ({busy, fail_code} !== {1'b1, 2'd0}) begin tests_failed++; $display("[TB] FAIL link_ignored: got busy %0b code %0d expected 1 0", busy, fail_code); end
      rx_ok = 1'b1;
      tick(2);
      rx_ok = 1'b0;
      tick(1);
      tests_run++;
      if ({done, pass} !== 2'b11) begin tests_failed++; $display("[TB] FAIL link_ignored_done: got done %0b pass %0b expected 1 1", done, pass); end
`endif
   endtask

   task automatic test_reset_mid_run();
      apply_reset();
      gen_ready = 1'b0;
      reach_send(8'd5, 14'd64);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tests_run++;
      if ({xaui_reset, gen_valid, busy, done} !== 4'b1000) begin tests_failed++; $display("[TB] FAIL reset_mid_run: got xrst/valid/busy/done %4b expected 1000", {xaui_reset, gen_valid, busy, done}); end
   endtask

   task automatic test_saturation();
      apply_reset();
      rx_ok = 1'b1; rx_err = 1'b1;
      tick(254);
      tests_run++;
      if ({rx_ok_cnt, rx_err_cnt} !== {8'd254, 8'd254}) begin tests_failed++; $display("[TB] FAIL sat_254: got %0d/%0d expected 254/254", rx_ok_cnt, rx_err_cnt); end
      tick(46);
      rx_ok = 1'b0; rx_err = 1'b0;
      tests_run++;
      if ({rx_ok_cnt, rx_err_cnt} !== {8'hFF, 8'hFF}) begin tests_failed++; $display("[TB] FAIL sat_hold: got %0d/%0d expected 255/255", rx_ok_cnt, rx_err_cnt); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      cfg_count = '0; cfg_len = '0; sync_status = 4'h0; align_status = 1'b0;
      gen_ready = 1'b0; rx_ok = 1'b0; rx_err = 1'b0;
      tick(2);
      test_reset();
      reset = 1'b0;
      test_link_rst_window();
      test_full_run();
      test_align_timeout();
      test_ready_throttle();
      test_mixed_results();
      test_abort();
      test_drain_timeout();
      test_link_loss();
      test_reset_mid_run();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
